// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array scheduler: FSM state encoding and the
// result-row layout at the default array geometry.
package sys_array_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_A_W        = 4;
  localparam int DEF_A_L        = 4;
  localparam int DEF_W_L        = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    FLUSH = 3'd4
  } state_t;

  typedef struct packed {
    logic                                       last;
    logic [DEF_W_L-1:0][2*DEF_DATA_WIDTH-1:0]   data;
  } res_row_t;

endpackage

// File: rtl/sys_array_res_fifo.sv
// Result FIFO: DEPTH entries, simultaneous read/write, zero on the read port
// while empty so idle outputs stay quiet.
module sys_array_res_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr, do_rd;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_wr   = wr_en && (count != CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sys_array_scheduler.sv
// Job scheduler for a weight-stationary systolic array: loads weights, skews A
// rows into the array, tags slots, deskews result columns into a result FIFO.
module sys_array_scheduler
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_A_W  = DEF_A_W,
  parameter int ARRAY_A_L  = DEF_A_L,
  parameter int ARRAY_W_L  = DEF_W_L,
  parameter int PIPE_LAT   = ARRAY_A_L + 1
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  input  logic                                    a_valid,
  output logic                                    a_ready,
  input  logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0]    a_data,
  output logic                                    weights_load,
  output logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0]    arr_in,
  input  logic [ARRAY_W_L-1:0][2*DATA_WIDTH-1:0]  arr_out,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [ARRAY_W_L-1:0][2*DATA_WIDTH-1:0]  res_data,
  output logic                                    res_last,
  output state_t                                  fsm_state
);
  localparam int RW    = 2 * DATA_WIDTH;
  localparam int TAG_D = PIPE_LAT + ARRAY_W_L - 1;
  localparam int CW    = $clog2(ARRAY_A_W + 1);
  localparam int FW    = 1 + ARRAY_W_L * RW;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and data is held by the source until taken.
  state_t                              state_q, state_d;
  logic                                accept, drained, fifo_empty, wr_en, wr_last;
  logic [CW-1:0]                       acc_cnt, wr_cnt;
  logic [TAG_D-1:0]                    tag_sr;
  logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0] row_in;
  logic [ARRAY_W_L-1:0][RW-1:0]        wr_row;
  logic [FW-1:0]                       rd_word;

  assign accept  = a_valid && (state_q == FEED);
  assign drained = ~|tag_sr;
  assign row_in  = accept ? a_data : '0;
  assign wr_en   = tag_sr[TAG_D-1];
  assign wr_last = (wr_cnt == CW'(ARRAY_A_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b1;
    done         = 1'b0;
    a_ready      = 1'b0;
    weights_load = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        weights_load = 1'b1;
        state_d      = FEED;
      end
      FEED: begin
        a_ready = 1'b1;
        if (a_valid && (acc_cnt == CW'(ARRAY_A_W - 1))) state_d = DRAIN;
      end
      DRAIN: if (drained) state_d = FLUSH;
      FLUSH: begin
        if (fifo_empty) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fsm_state = state_q;

  // Bubbles shift a zero tag, so only real rows reach the FIFO write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt <= '0;
      wr_cnt  <= '0;
      tag_sr  <= '0;
    end else begin
      tag_sr <= (tag_sr << 1) | TAG_D'(accept);
      if (state_q == LOAD) begin
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + CW'(1);
        if (wr_en)  wr_cnt  <= wr_cnt + CW'(1);
      end
    end
  end

  assign arr_in[0] = row_in[0];

  for (genvar j = 1; j < ARRAY_A_L; j++) begin : g_skew
    logic [j-1:0][DATA_WIDTH-1:0] sk;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sk <= '0;
      end else begin
        sk[0] <= row_in[j];
        for (int k = 1; k < j; k++) sk[k] <= sk[k-1];
      end
    end
    assign arr_in[j] = sk[j-1];
  end

  // Column t is valid PIPE_LAT+t after acceptance; delay it so every column
  // lines up with the last one, which is taken straight from arr_out.
  assign wr_row[ARRAY_W_L-1] = arr_out[ARRAY_W_L-1];

  for (genvar t = 0; t < ARRAY_W_L - 1; t++) begin : g_deskew
    localparam int N = ARRAY_W_L - 1 - t;
    logic [N-1:0][RW-1:0] dk;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dk <= '0;
      end else begin
        dk[0] <= arr_out[t];
        for (int k = 1; k < N; k++) dk[k] <= dk[k-1];
      end
    end
    assign wr_row[t] = dk[N-1];
  end

  sys_array_res_fifo #(
    .WIDTH (FW),
    .DEPTH (ARRAY_A_W)
  ) u_res_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data ({wr_last, wr_row}),
    .rd_en   (res_ready),
    .rd_data (rd_word),
    .empty   (fifo_empty)
  );

  assign res_valid            = !fifo_empty;
  assign {res_last, res_data} = rd_word;

endmodule
